stopwatch_counter: RTL and testbench

- Seconds/minutes timebase with start/pause/clear control.
- Produces the registered time values `sec_o`/`min_o` and a one-cycle `tick_o` strobe.
- Sits directly upstream of the 6-bit enable-gated holding registers: `tick_o` drives their `en`, and `sec_o`/`min_o` drive their `D`.
- Control inputs arrive as already-synchronised, single-cycle pulses from the button front end.

---
 rtl/stopwatch_counter.sv | 111 +++++++++++
 tb/tb_stopwatch_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// Seconds/minutes stopwatch timebase with start/pause/clear control.
// Latency: running_o follows a start_stop_i pulse by one edge; tick_o/wrap_o are registered one-cycle pulses.
// No backpressure: every control pulse is acted on in the cycle it is sampled; consumers must accept every tick.
module stopwatch_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] sec_o,
    output logic [CNT_W-1:0] min_o,
    output logic             running_o,
    output logic             tick_o,
    output logic             wrap_o
);

    // Prescaler needs at least one bit even when TICK_DIV is 1 (it then stays at 0).
    localparam int                PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(59);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] prescale;

    // A second boundary is reached only while running and the prescaler is at its last count.
    logic at_terminal;
    logic sec_last;
    logic min_last;

    assign at_terminal = (state == RUN) && (prescale == PRE_LAST);
    assign sec_last    = (sec_o == CNT_LAST);
    assign min_last    = (min_o == CNT_LAST);

    // Control FSM, prescaler, time fields and registered strobes; clear overrides any toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prescale  <= '0;
            sec_o     <= '0;
            min_o     <= '0;
            running_o <= 1'b0;
            tick_o    <= 1'b0;
            wrap_o    <= 1'b0;
        end else if (clear_i) begin
            state     <= IDLE;
            prescale  <= '0;
            sec_o     <= '0;
            min_o     <= '0;
            running_o <= 1'b0;
            tick_o    <= 1'b0;
            wrap_o    <= 1'b0;
        end else begin
            tick_o <= 1'b0;
            wrap_o <= 1'b0;

            // Time only moves in RUN; PAUSE/IDLE keep the partial second intact.
            if (state == RUN) begin
                if (at_terminal) begin
                    prescale <= '0;
                    tick_o   <= 1'b1;
                    if (sec_last) begin
                        sec_o <= '0;
                        if (min_last) begin
                            min_o  <= '0;
                            wrap_o <= 1'b1;
                        end else begin
                            min_o <= min_o + CNT_ONE;
                        end
                    end else begin
                        sec_o <= sec_o + CNT_ONE;
                    end
                end else begin
                    prescale <= prescale + PRE_ONE;
                end
            end

            // A toggle on the terminal cycle still lets the advance above complete.
            if (start_stop_i) begin
                case (state)
                    IDLE: begin
                        state     <= RUN;
                        running_o <= 1'b1;
                    end
                    RUN: begin
                        state     <= PAUSE;
                        running_o <= 1'b0;
                    end
                    PAUSE: begin
                        state     <= RUN;
                        running_o <= 1'b1;
                    end
                    default: begin
                        state     <= IDLE;
                        running_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

    localparam int W = 6;

    logic clk = 1'b0;
    logic rst;
    logic ss4, clr4, ss1, clr1;
    logic [W-1:0] sec4, min4, sec1, min1;
    logic run4, tick4, wrap4, run1, tick1, wrap1;

    always #5 clk = ~clk;

    stopwatch_counter #(.TICK_DIV(4), .CNT_W(W)) dut4 (
        .clk(clk), .rst(rst), .start_stop_i(ss4), .clear_i(clr4),
        .sec_o(sec4), .min_o(min4), .running_o(run4), .tick_o(tick4), .wrap_o(wrap4)
    );

    stopwatch_counter #(.TICK_DIV(1), .CNT_W(W)) dut1 (
        .clk(clk), .rst(rst), .start_stop_i(ss1), .clear_i(clr1),
        .sec_o(sec1), .min_o(min1), .running_o(run1), .tick_o(tick1), .wrap_o(wrap1)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference: elapsed whole seconds modulo one hour, plus the phase within the current second.
    // mode: 0 = stopped at zero, 1 = counting, 2 = paused
    int m_mode[2];
    int m_phase[2];
    int m_total[2];
    int m_tick[2];
    int m_wrap[2];
    int m_div[2] = '{4, 1};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_phase[i] = 0; m_total[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit ss, input bit clr);
        m_tick[i] = 0;
        m_wrap[i] = 0;
        if (clr) begin
            m_mode[i] = 0; m_phase[i] = 0; m_total[i] = 0;
        end else begin
            if (m_mode[i] == 1) begin
                m_phase[i] = m_phase[i] + 1;
                if (m_phase[i] == m_div[i]) begin
                    m_phase[i] = 0;
                    m_total[i] = (m_total[i] + 1) % 3600;
                    m_tick[i]  = 1;
                    m_wrap[i]  = (m_total[i] == 0) ? 1 : 0;
                end
            end
            if (ss) m_mode[i] = (m_mode[i] == 1) ? 2 : 1;
        end
    endtask

    task automatic compare_all();
        check("d4_sec",  sec4,  m_total[0] % 60);
        check("d4_min",  min4,  m_total[0] / 60);
        check("d4_run",  run4,  (m_mode[0] == 1) ? 1 : 0);
        check("d4_tick", tick4, m_tick[0]);
        check("d4_wrap", wrap4, m_wrap[0]);
        check("d1_sec",  sec1,  m_total[1] % 60);
        check("d1_min",  min1,  m_total[1] / 60);
        check("d1_run",  run1,  (m_mode[1] == 1) ? 1 : 0);
        check("d1_tick", tick1, m_tick[1]);
        check("d1_wrap", wrap1, m_wrap[1]);
    endtask

    // Inputs are driven 1 ns after an edge, sampled at the next edge, outputs compared 1 ns after it.
    task automatic cycle(input bit s4, input bit c4, input bit s1, input bit c1);
        ss4 = s4; clr4 = c4; ss1 = s1; clr1 = c1;
        @(posedge clk);
        model_step(0, s4, c4);
        model_step(1, s1, c1);
        #1;
        ss4 = 1'b0; clr4 = 1'b0; ss1 = 1'b0; clr1 = 1'b0;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
    endtask

    int wrap_cnt;
    int wrap_at;
    int tick_cnt;

    initial begin
        ss4 = 0; clr4 = 0; ss1 = 0; clr1 = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // 1: start, ticks every 4 cycles
        cycle(1, 0, 0, 0);
        check("p1_running", run4, 1);
        idle_cycles(4);
        check("p1_sec_after4", sec4, 1);
        check("p1_tick_after4", tick4, 1);
        idle_cycles(4);
        check("p1_sec_after8", sec4, 2);
        idle_cycles(4);
        check("p1_sec_after12", sec4, 3);

        // 2: run up to 0:59, then one more second carries into minutes
        idle_cycles(56 * 4);
        check("p2_sec59", sec4, 59);
        check("p2_min0", min4, 0);
        idle_cycles(4);
        check("p2_sec_carry", sec4, 0);
        check("p2_min_carry", min4, 1);
        check("p2_tick", tick4, 1);
        check("p2_wrap", wrap4, 0);

        // 3: one full hour at one advance per cycle
        cycle(0, 0, 1, 0);
        wrap_cnt = 0;
        wrap_at  = -1;
        for (int k = 1; k <= 3600; k++) begin
            cycle(0, 0, 0, 0);
            if (wrap1) begin
                wrap_cnt++;
                wrap_at = k;
            end
        end
        check("p3_wrap_count", wrap_cnt, 1);
        check("p3_wrap_at", wrap_at, 3600);
        check("p3_sec", sec1, 0);
        check("p3_min", min1, 0);

        // 4: pause retains the partial second
        cycle(0, 1, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("p4_paused", run4, 0);
        tick_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0, 0);
            if (tick4) tick_cnt++;
        end
        check("p4_no_tick", tick_cnt, 0);
        check("p4_sec_held", sec4, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("p4_tick_not_yet", tick4, 0);
        cycle(0, 0, 0, 0);
        check("p4_tick_resume", tick4, 1);
        check("p4_sec_resume", sec4, 1);

        // 5: clear beats a simultaneous toggle
        idle_cycles(16 * 4);
        check("p5_sec17", sec4, 17);
        cycle(1, 1, 0, 0);
        check("p5_sec", sec4, 0);
        check("p5_min", min4, 0);
        check("p5_running", run4, 0);
        idle_cycles(8);
        check("p5_stays_idle", sec4, 0);

        // random control pulses on both instances
        for (int k = 0; k < 2000; k++) begin
            cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0));
        end

        // 6: asynchronous reset mid-count at 5:33
        cycle(0, 1, 0, 1);
        cycle(1, 0, 1, 0);
        idle_cycles(333 * 4);
        check("p6_sec33", sec4, 33);
        check("p6_min5", min4, 5);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("p6_rst_sec", sec4, 0);
        check("p6_rst_min", min4, 0);
        check("p6_rst_run", run4, 0);
        check("p6_rst_tick", tick4, 0);
        check("p6_rst_wrap", wrap4, 0);
        compare_all();
        #2 rst = 1'b0;
        idle_cycles(10);
        check("p6_idle_run", run4, 0);
        check("p6_idle_sec", sec4, 0);
        cycle(1, 0, 1, 0);
        idle_cycles(9);
        check("p6_restart_sec", sec4, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
